// File: rtl/stage_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stage_seq_ctrl
// Brief    : Multi-cycle stage sequencer for the 16-bit DSD processor.
//            Generates per-stage write enables and handles the MEM handshake,
//            UART back-pressure, HALT and the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module stage_seq_ctrl #(
    parameter int MEM_LAT = 0,
    parameter int USE_ACK = 0,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_inst,
    input  logic             mem_force,
    input  logic             send_inst,
    input  logic             halt,
    input  logic             dmem_ack,
    input  logic             uart_busy,
    output logic             IR_Wen,
    output logic             PC_Wen,
    output logic             PSR_Wen,
    output logic             RF_Wen,
    output logic             ST_Wen,
    output logic             EXSTtoMEM_Wen,
    output logic             dmem_req,
    output logic             uart_send,
    output logic             stall,
    output logic             mem_err,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_EX   = 3'd1,
        S_MEM  = 3'd2,
        S_SEND = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam int                c_TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);
    localparam logic [3:0]        c_MEM_LAT  = 4'(MEM_LAT);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam bit                c_USE_ACK  = (USE_ACK != 0);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_wait;
    logic [c_TO_W-1:0]   r_to;
    logic [CNT_W-1:0]    r_inst_cnt;
    logic [CNT_W-1:0]    r_cyc_cnt;
    logic                r_mem_err;

    logic w_wait_done;
    logic w_to_expired;
    logic w_mem_done;
    logic w_mem_timeout;

    logic w_ir_wen;
    logic w_pc_wen;
    logic w_psr_wen;
    logic w_rf_wen;
    logic w_st_wen;
    logic w_exm_wen;
    logic w_dmem_req;
    logic w_uart_send;
    logic w_stall;
    logic w_retire;
    logic w_enter_mem;

    assign w_wait_done   = (r_wait == 4'd0);
    assign w_to_expired  = (r_to == c_TO_LAST);
    assign w_mem_done    = w_wait_done && (!c_USE_ACK || dmem_ack || w_to_expired);
    // Forced completion only counts as an error when the ack never arrived.
    assign w_mem_timeout = c_USE_ACK && w_wait_done && !dmem_ack && w_to_expired;

    always_comb begin
        w_next      = r_state;
        w_ir_wen    = 1'b0;
        w_pc_wen    = 1'b0;
        w_psr_wen   = 1'b0;
        w_rf_wen    = 1'b0;
        w_st_wen    = 1'b0;
        w_exm_wen   = 1'b0;
        w_dmem_req  = 1'b0;
        w_uart_send = 1'b0;
        w_stall     = 1'b0;
        w_retire    = 1'b0;
        w_enter_mem = 1'b0;
        case (r_state)
            S_IF: begin
                w_ir_wen = 1'b1;
                w_next   = S_EX;
            end
            S_EX: begin
                w_psr_wen = 1'b1;
                w_st_wen  = 1'b1;
                w_exm_wen = 1'b1;
                if (halt) begin
                    w_next = S_HALT;
                end else if (send_inst) begin
                    w_next = S_SEND;
                end else if (mem_inst || mem_force) begin
                    w_next      = S_MEM;
                    w_enter_mem = 1'b1;
                end else begin
                    w_rf_wen = 1'b1;
                    w_pc_wen = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_IF;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                if (w_mem_done) begin
                    w_rf_wen = 1'b1;
                    // Multi-register push/pop loops back to EX without retiring.
                    if (mem_force) begin
                        w_st_wen = 1'b1;
                        w_next   = S_EX;
                    end else begin
                        w_pc_wen = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_IF;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_SEND: begin
                if (uart_busy) begin
                    w_stall = 1'b1;
                end else begin
                    w_uart_send = 1'b1;
                    w_pc_wen    = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = S_IF;
                end
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IF;
            r_wait     <= 4'd0;
            r_to       <= '0;
            r_inst_cnt <= '0;
            r_cyc_cnt  <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter_mem) begin
                r_wait <= c_MEM_LAT;
                r_to   <= '0;
            end else if (r_state == S_MEM) begin
                if (!w_wait_done) begin
                    r_wait <= r_wait - 4'd1;
                end else if (!w_to_expired) begin
                    r_to <= r_to + c_TO_ONE;
                end
            end
            if ((r_state == S_MEM) && w_mem_timeout) begin
                r_mem_err <= 1'b1;
            end
            if ((r_state != S_HALT) && (r_cyc_cnt != c_CNT_MAX)) begin
                r_cyc_cnt <= r_cyc_cnt + c_CNT_ONE;
            end
            if (w_retire && (r_inst_cnt != c_CNT_MAX)) begin
                r_inst_cnt <= r_inst_cnt + c_CNT_ONE;
            end
        end
    end

    // Strobes are held low throughout reset regardless of the state register.
    assign IR_Wen        = resetn & w_ir_wen;
    assign PC_Wen        = resetn & w_pc_wen;
    assign PSR_Wen       = resetn & w_psr_wen;
    assign RF_Wen        = resetn & w_rf_wen;
    assign ST_Wen        = resetn & w_st_wen;
    assign EXSTtoMEM_Wen = resetn & w_exm_wen;
    assign dmem_req      = resetn & w_dmem_req;
    assign uart_send     = resetn & w_uart_send;
    assign stall         = resetn & w_stall;

    assign mem_err     = r_mem_err;
    assign stage       = r_state;
    assign inst_count  = r_inst_cnt;
    assign cycle_count = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stage_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_seq_ctrl
// Brief    : Directed self-checking bench for stage_seq_ctrl using three
//            differently parameterised instances driven by shared inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_seq_ctrl;

    // Enable vector order: {IR,PC,PSR,RF,ST,EXSTtoMEM,dmem_req,uart_send,stall}
    localparam logic [8:0] c_EN_IF    = 9'b100000000;
    localparam logic [8:0] c_EN_EXA   = 9'b011111000;
    localparam logic [8:0] c_EN_EXM   = 9'b001011000;
    localparam logic [8:0] c_EN_MEMW  = 9'b000000101;
    localparam logic [8:0] c_EN_MEMD  = 9'b010100100;
    localparam logic [8:0] c_EN_MEMF  = 9'b000110100;
    localparam logic [8:0] c_EN_SENDB = 9'b000000001;
    localparam logic [8:0] c_EN_SENDG = 9'b010000010;
    localparam logic [8:0] c_EN_NONE  = 9'b000000000;

    logic clk = 1'b0;
    logic resetn, mem_inst, mem_force, send_inst, halt, dmem_ack, uart_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // d0: MEM_LAT=0, no ack, 4-bit counters
    logic d0_ir, d0_pc, d0_psr, d0_rf, d0_st, d0_exm, d0_req, d0_send, d0_stall, d0_err;
    logic [2:0] d0_stage;
    logic [3:0] d0_inst, d0_cyc;
    logic [8:0] d0_en;
    assign d0_en = {d0_ir, d0_pc, d0_psr, d0_rf, d0_st, d0_exm, d0_req, d0_send, d0_stall};

    stage_seq_ctrl #(.MEM_LAT(0), .USE_ACK(0), .TIMEOUT(64), .CNT_W(4)) u_d0 (
        .clk(clk), .resetn(resetn), .mem_inst(mem_inst), .mem_force(mem_force),
        .send_inst(send_inst), .halt(halt), .dmem_ack(dmem_ack), .uart_busy(uart_busy),
        .IR_Wen(d0_ir), .PC_Wen(d0_pc), .PSR_Wen(d0_psr), .RF_Wen(d0_rf), .ST_Wen(d0_st),
        .EXSTtoMEM_Wen(d0_exm), .dmem_req(d0_req), .uart_send(d0_send), .stall(d0_stall),
        .mem_err(d0_err), .stage(d0_stage), .inst_count(d0_inst), .cycle_count(d0_cyc)
    );

    // d3: MEM_LAT=3, no ack
    logic d3_ir, d3_pc, d3_psr, d3_rf, d3_st, d3_exm, d3_req, d3_send, d3_stall, d3_err;
    logic [2:0] d3_stage;
    logic [7:0] d3_inst, d3_cyc;
    logic [8:0] d3_en;
    assign d3_en = {d3_ir, d3_pc, d3_psr, d3_rf, d3_st, d3_exm, d3_req, d3_send, d3_stall};

    stage_seq_ctrl #(.MEM_LAT(3), .USE_ACK(0), .TIMEOUT(64), .CNT_W(8)) u_d3 (
        .clk(clk), .resetn(resetn), .mem_inst(mem_inst), .mem_force(mem_force),
        .send_inst(send_inst), .halt(halt), .dmem_ack(dmem_ack), .uart_busy(uart_busy),
        .IR_Wen(d3_ir), .PC_Wen(d3_pc), .PSR_Wen(d3_psr), .RF_Wen(d3_rf), .ST_Wen(d3_st),
        .EXSTtoMEM_Wen(d3_exm), .dmem_req(d3_req), .uart_send(d3_send), .stall(d3_stall),
        .mem_err(d3_err), .stage(d3_stage), .inst_count(d3_inst), .cycle_count(d3_cyc)
    );

    // da: MEM_LAT=0, ack handshake with TIMEOUT=8
    logic da_ir, da_pc, da_psr, da_rf, da_st, da_exm, da_req, da_send, da_stall, da_err;
    logic [2:0] da_stage;
    logic [7:0] da_inst, da_cyc;
    logic [8:0] da_en;
    assign da_en = {da_ir, da_pc, da_psr, da_rf, da_st, da_exm, da_req, da_send, da_stall};

    stage_seq_ctrl #(.MEM_LAT(0), .USE_ACK(1), .TIMEOUT(8), .CNT_W(8)) u_da (
        .clk(clk), .resetn(resetn), .mem_inst(mem_inst), .mem_force(mem_force),
        .send_inst(send_inst), .halt(halt), .dmem_ack(dmem_ack), .uart_busy(uart_busy),
        .IR_Wen(da_ir), .PC_Wen(da_pc), .PSR_Wen(da_psr), .RF_Wen(da_rf), .ST_Wen(da_st),
        .EXSTtoMEM_Wen(da_exm), .dmem_req(da_req), .uart_send(da_send), .stall(da_stall),
        .mem_err(da_err), .stage(da_stage), .inst_count(da_inst), .cycle_count(da_cyc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_inst = 1'b0; mem_force = 1'b0; send_inst = 1'b0;
        halt = 1'b0; dmem_ack = 1'b0; uart_busy = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mem_inst = 1'b1; send_inst = 1'b1; uart_busy = 1'b1; dmem_ack = 1'b1;
        #1;
        vectors++;
        if (d0_en !== c_EN_NONE) begin
            miscompares++; $display("FAIL reset_en_pre got %b exp %b", d0_en, c_EN_NONE);
        end
        step();
        vectors++;
        if (d0_en !== c_EN_NONE) begin
            miscompares++; $display("FAIL reset_en got %b exp %b", d0_en, c_EN_NONE);
        end
        vectors++;
        if ({d0_stage, d0_inst, d0_cyc, d0_err} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_state got stage=%0d inst=%0d cyc=%0d err=%0d exp all 0",
                     d0_stage, d0_inst, d0_cyc, d0_err);
        end
        vectors++;
        if (da_err !== 1'b0 || da_stage !== 3'd0) begin
            miscompares++; $display("FAIL reset_da got err=%0d stage=%0d exp 0 0", da_err, da_stage);
        end
        clear_inputs();
        resetn = 1'b1;
        #1;
        vectors++;
        if (d0_en !== c_EN_IF) begin
            miscompares++; $display("FAIL reset_release_en got %b exp %b", d0_en, c_EN_IF);
        end
    endtask

    task automatic test_alu();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++;
            if (d0_stage !== 3'(i % 2) || d0_en !== ((i % 2) ? c_EN_EXA : c_EN_IF)) begin
                miscompares++;
                $display("FAIL alu_cycle%0d got stage=%0d en=%b exp stage=%0d en=%b",
                         i, d0_stage, d0_en, i % 2, (i % 2) ? c_EN_EXA : c_EN_IF);
            end
            step();
        end
        vectors++;
        if (d0_inst !== 4'd4 || d0_cyc !== 4'd8) begin
            miscompares++;
            $display("FAIL alu_counts got inst=%0d cyc=%0d exp inst=4 cyc=8", d0_inst, d0_cyc);
        end
    endtask

    task automatic test_load_latency();
        do_reset();
        mem_inst = 1'b1;
        step();
        vectors++;
        if (d3_stage !== 3'd1 || d3_en !== c_EN_EXM) begin
            miscompares++;
            $display("FAIL load_ex got stage=%0d en=%b exp 1 %b", d3_stage, d3_en, c_EN_EXM);
        end
        step();
        mem_inst = 1'b0;
        for (int m = 0; m < 4; m++) begin
            #1;
            vectors++;
            if (d3_stage !== 3'd2 || d3_en !== ((m == 3) ? c_EN_MEMD : c_EN_MEMW)) begin
                miscompares++;
                $display("FAIL load_mem%0d got stage=%0d en=%b exp 2 %b",
                         m, d3_stage, d3_en, (m == 3) ? c_EN_MEMD : c_EN_MEMW);
            end
            step();
        end
        vectors++;
        if (d3_stage !== 3'd0 || d3_inst !== 8'd1 || d3_cyc !== 8'd6) begin
            miscompares++;
            $display("FAIL load_after got stage=%0d inst=%0d cyc=%0d exp 0 1 6",
                     d3_stage, d3_inst, d3_cyc);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_inst = 1'b1;
        step();
        step();
        mem_inst = 1'b0;
        for (int m = 0; m < 8; m++) begin
            #1;
            vectors++;
            if (da_en !== ((m == 7) ? c_EN_MEMD : c_EN_MEMW) || da_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_mem%0d got en=%b err=%0d exp %b 0",
                         m, da_en, da_err, (m == 7) ? c_EN_MEMD : c_EN_MEMW);
            end
            step();
        end
        vectors++;
        if (da_stage !== 3'd0 || da_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_after got stage=%0d err=%0d exp 0 1", da_stage, da_err);
        end
        step();
        step();
        vectors++;
        if (da_err !== 1'b1 || da_inst !== 8'd2) begin
            miscompares++;
            $display("FAIL timeout_sticky got err=%0d inst=%0d exp 1 2", da_err, da_inst);
        end
        // Load completed by ack on its third MEM cycle.
        mem_inst = 1'b1;
        step();
        step();
        mem_inst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            dmem_ack = (m == 2);
            #1;
            vectors++;
            if (da_en !== ((m == 2) ? c_EN_MEMD : c_EN_MEMW)) begin
                miscompares++;
                $display("FAIL ack_mem%0d got en=%b exp %b",
                         m, da_en, (m == 2) ? c_EN_MEMD : c_EN_MEMW);
            end
            step();
        end
        dmem_ack = 1'b0;
        vectors++;
        if (da_stage !== 3'd0 || da_err !== 1'b1 || da_inst !== 8'd3) begin
            miscompares++;
            $display("FAIL ack_after got stage=%0d err=%0d inst=%0d exp 0 1 3",
                     da_stage, da_err, da_inst);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        vectors++;
        if (da_err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_reset got err=%0d exp 0", da_err);
        end
    endtask

    task automatic test_push();
        logic [2:0] exp_stage [0:7];
        logic [8:0] exp_en    [0:7];
        exp_stage[0] = 3'd0; exp_en[0] = c_EN_IF;
        exp_stage[1] = 3'd1; exp_en[1] = c_EN_EXM;
        exp_stage[2] = 3'd2; exp_en[2] = c_EN_MEMF;
        exp_stage[3] = 3'd1; exp_en[3] = c_EN_EXM;
        exp_stage[4] = 3'd2; exp_en[4] = c_EN_MEMF;
        exp_stage[5] = 3'd1; exp_en[5] = c_EN_EXM;
        exp_stage[6] = 3'd2; exp_en[6] = c_EN_MEMD;
        exp_stage[7] = 3'd0; exp_en[7] = c_EN_IF;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem_inst  = (i < 6);
            mem_force = (i < 6);
            #1;
            vectors++;
            if (d0_stage !== exp_stage[i] || d0_en !== exp_en[i]) begin
                miscompares++;
                $display("FAIL push_cycle%0d got stage=%0d en=%b exp %0d %b",
                         i, d0_stage, d0_en, exp_stage[i], exp_en[i]);
            end
            step();
        end
        vectors++;
        if (d0_inst !== 4'd1) begin
            miscompares++; $display("FAIL push_inst got %0d exp 1", d0_inst);
        end
        clear_inputs();
    endtask

    task automatic test_send();
        do_reset();
        step();
        send_inst = 1'b1;
        uart_busy = 1'b1;
        step();
        send_inst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            uart_busy = (s < 5);
            #1;
            vectors++;
            if (d0_stage !== 3'd3 || d0_en !== ((s < 5) ? c_EN_SENDB : c_EN_SENDG)) begin
                miscompares++;
                $display("FAIL send_cycle%0d got stage=%0d en=%b exp 3 %b",
                         s, d0_stage, d0_en, (s < 5) ? c_EN_SENDB : c_EN_SENDG);
            end
            step();
        end
        vectors++;
        if (d0_stage !== 3'd0 || d0_send !== 1'b0 || d0_inst !== 4'd1) begin
            miscompares++;
            $display("FAIL send_after got stage=%0d send=%0d inst=%0d exp 0 0 1",
                     d0_stage, d0_send, d0_inst);
        end
    endtask

    task automatic test_halt_and_reset();
        do_reset();
        halt = 1'b1;
        step();
        vectors++;
        if (d0_en !== c_EN_EXM) begin
            miscompares++; $display("FAIL halt_ex got en=%b exp %b", d0_en, c_EN_EXM);
        end
        step();
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (d0_stage !== 3'd4 || d0_en !== c_EN_NONE || d0_cyc !== 4'd2 || d0_inst !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_hold got stage=%0d en=%b cyc=%0d inst=%0d exp 4 0 2 0",
                     d0_stage, d0_en, d0_cyc, d0_inst);
        end
        do_reset();
        vectors++;
        if (d0_stage !== 3'd0 || d0_cyc !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_reset got stage=%0d cyc=%0d exp 0 0", d0_stage, d0_cyc);
        end
        mem_inst = 1'b1;
        step();
        step();
        mem_inst = 1'b0;
        vectors++;
        if (d3_stage !== 3'd2 || d3_en !== c_EN_MEMW) begin
            miscompares++;
            $display("FAIL abort_mem got stage=%0d en=%b exp 2 %b", d3_stage, d3_en, c_EN_MEMW);
        end
        step();
        resetn = 1'b0;
        #1;
        vectors++;
        if (d3_en !== c_EN_NONE) begin
            miscompares++; $display("FAIL abort_en got %b exp %b", d3_en, c_EN_NONE);
        end
        step();
        vectors++;
        if (d3_stage !== 3'd0 || d3_inst !== 8'd0 || d3_cyc !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_state got stage=%0d inst=%0d cyc=%0d exp 0 0 0",
                     d3_stage, d3_inst, d3_cyc);
        end
        resetn = 1'b1;
        #1;
        vectors++;
        if (d3_en !== c_EN_IF) begin
            miscompares++; $display("FAIL abort_release got %b exp %b", d3_en, c_EN_IF);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 34; i++) step();
        vectors++;
        if (d0_cyc !== 4'd15 || d0_inst !== 4'd15) begin
            miscompares++;
            $display("FAIL saturate got cyc=%0d inst=%0d exp 15 15", d0_cyc, d0_inst);
        end
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_alu();
        test_load_latency();
        test_timeout();
        test_push();
        test_send();
        test_halt_and_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_seq_ctrl.md
Name: stage_seq_ctrl

Overview:
Parametrised multi-cycle stage sequencer for the 16-bit DSD processor. It is the next-generation stage controller, and it generates the per-stage write enables for IR, PC, PSR, RF, ST and the EX/ST-to-MEM register. It adds features the previous controller lacks:
- configurable memory latency;
- optional dmem request/acknowledge handshake with timeout;
- UART-busy back-pressure;
- HALT state;
- retired-instruction and cycle performance counters.

Parameters:
MEM_LAT, 0, fixed wait cycles in MEM before completion is allowed (0..15)
USE_ACK, 0, 1 = MEM completion also requires dmem_ack; 0 = ignore dmem_ack
TIMEOUT, 64, max cycles in MEM waiting for dmem_ack before forced completion (USE_ACK=1 only)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
mem_inst  in  1  decoded instruction needs MEM stage (load/store)
mem_force  in  1  stack unit requests another MEM transfer (multi-register push/pop)
send_inst  in  1  decoded instruction is UART send
halt  in  1  decoded instruction is HALT
dmem_ack  in  1  data memory transfer done
uart_busy  in  1  UART transmitter busy
IR_Wen  out  1  instruction register write
PC_Wen  out  1  PC update
PSR_Wen  out  1  flags update
RF_Wen  out  1  register file write strobe
ST_Wen  out  1  stack unit advance
EXSTtoMEM_Wen  out  1  EX/ST-to-MEM register load
dmem_req  out  1  data memory request
uart_send  out  1  one-cycle UART start pulse
stall  out  1  high in MEM/SEND while waiting
mem_err  out  1  sticky dmem timeout flag
stage  out  3  current state encoding
inst_count  out  CNT_W  retired instructions
cycle_count  out  CNT_W  active cycles

Behaviour:
- All state updates occur on the clk rising edge.
- resetn=0 at an edge:
  - state <- IF;
  - wait/timeout counters, inst_count, cycle_count and mem_err <- 0.
- While resetn=0, every enable output, dmem_req, uart_send and stall is forced to 0.
- resetn mid-operation abandons any MEM or SEND in progress. No retire is counted for it.
- State encoding on stage: IF=0, EX=1, MEM=2, SEND=3, HALT=4.
- Enables are decoded combinationally from the state and the inputs. They are meaningful only while resetn=1.
- IF: IR_Wen=1. Next state EX.
- EX: PSR_Wen=1, ST_Wen=1, EXSTtoMEM_Wen=1. Input priority is halt > send_inst > (mem_inst|mem_force):
  - halt -> HALT. No PC update.
  - send_inst -> SEND.
  - mem_inst|mem_force -> MEM. Wait counter loads MEM_LAT; timeout counter loads 0.
  - none -> RF_Wen=1, PC_Wen=1, retire, next IF. This is a 2-cycle instruction.
- MEM:
  - dmem_req=1 every cycle.
  - Wait counter decrements to 0 and holds there.
  - Completion condition: wait counter==0 AND (USE_ACK=0 OR dmem_ack=1 OR timeout counter==TIMEOUT-1).
  - Completion by timeout sets mem_err (sticky until reset).
  - On completion: RF_Wen=1 (RF mux decides load vs store).
    - If mem_force=1: ST_Wen=1, next EX, no PC update, no retire.
    - Otherwise: PC_Wen=1, retire, next IF.
  - Until completion: stall=1, all other enables 0.
  - dmem_ack outside MEM is ignored.
  - MEM_LAT=0, USE_ACK=0 gives exactly one MEM cycle (3-cycle load/store).
- SEND:
  - If uart_busy=0: uart_send=1 for that cycle, PC_Wen=1, retire, next IF.
  - If uart_busy=1: stall=1, remain in SEND.
  - uart_send is never high in two consecutive cycles.
- HALT: all enables 0 and stall=0. Stays in HALT until reset. cycle_count frozen.
- Counters:
  - cycle_count +1 every cycle with resetn=1 and state!=HALT.
  - inst_count +1 on each retire.
  - Both saturate at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - mem_inst and mem_force together are treated as one MEM entry.
  - halt wins over all other inputs in EX.
- Timeout counter increments only while wait counter==0 in MEM.

Test Plan:
- ALU-only stream of 4 instructions, MEM_LAT=0 -> stage sequence 0,1,0,1…; inst_count=4 and cycle_count=8 after 8 cycles; PC_Wen and RF_Wen high only in EX.
- Load with MEM_LAT=3, USE_ACK=0 -> MEM lasts 4 cycles; stall=1 for the first 3; RF_Wen and PC_Wen high on the 4th; inst_count +1.
- USE_ACK=1, TIMEOUT=8, dmem_ack never asserted -> forced completion after 8 MEM cycles (MEM_LAT=0); mem_err=1 and stays 1 through later instructions.
- Push of 3 registers (mem_force high for 2 completions) -> EX,MEM,EX,MEM,EX,MEM,IF; PC_Wen once; inst_count +1 only.
- send_inst with uart_busy high for 5 cycles -> SEND held 5 cycles with stall=1; one uart_send pulse on the 6th cycle; next IF.
- halt in EX, then resetn low for 1 cycle during a MEM wait -> HALT freezes cycle_count; reset returns stage=0; counters and mem_err 0; no spurious enables during reset.
